// File: rtl/core_mac_ctrl_if.sv
// Scheduler / memory / buffer signal bundle of the core MAC sequencer.
// master = scheduler side, slave = core_mac_ctrl.
interface core_mac_ctrl_if #(
  parameter int GBUS_ADDR = 12,
  parameter int LBUF_ADDR = 4,
  parameter int CDATA_BIT = 8
);
  logic                 start;
  logic [GBUS_ADDR-1:0] cfg_base_addr;
  logic [CDATA_BIT-1:0] cfg_acc_num;
  logic [CDATA_BIT-1:0] cfg_row_num;
  logic                 mac_stall;
  logic [GBUS_ADDR-1:0] cmem_raddr;
  logic                 cmem_ren;
  logic [LBUF_ADDR-1:0] lbuf_waddr;
  logic                 lbuf_wen;
  logic [LBUF_ADDR-1:0] lbuf_raddr;
  logic                 lbuf_ren;
  logic [LBUF_ADDR-1:0] abuf_raddr;
  logic                 abuf_ren;
  logic                 acc_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, cfg_base_addr, cfg_acc_num,
    output cfg_row_num, mac_stall,
    input  cmem_raddr, cmem_ren,
    input  lbuf_waddr, lbuf_wen,
    input  lbuf_raddr, lbuf_ren,
    input  abuf_raddr, abuf_ren,
    input  acc_last, busy, done
  );

  modport slave (
    input  start, cfg_base_addr, cfg_acc_num,
    input  cfg_row_num, mac_stall,
    output cmem_raddr, cmem_ren,
    output lbuf_waddr, lbuf_wen,
    output lbuf_raddr, lbuf_ren,
    output abuf_raddr, abuf_ren,
    output acc_last, busy, done
  );
endinterface

// File: rtl/core_mac_ctrl.sv
// Single-job sequencer: streams core memory into the LBUF ring
// and drains LBUF/ABUF into the MAC line, tagging row ends.
module core_mac_ctrl #(
  parameter int GBUS_ADDR  = 12,
  parameter int LBUF_DEPTH = 16,
  parameter int LBUF_ADDR  = 4,
  parameter int CDATA_BIT  = 8
) (
  input logic clk,
  input logic rst,
  core_mac_ctrl_if.slave bus
);

  localparam int NW = 2 * CDATA_BIT;
  localparam logic [LBUF_ADDR:0] FULL =
    (LBUF_ADDR+1)'(LBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [GBUS_ADDR-1:0] base;
  logic [CDATA_BIT-1:0] acc;
  logic [CDATA_BIT-1:0] idx;
  logic [NW-1:0]        total;
  logic [NW-1:0]        issued;
  logic [NW-1:0]        consumed;
  logic [LBUF_ADDR:0]   occ;
  logic [LBUF_ADDR:0]   valid;
  logic [LBUF_ADDR-1:0] wptr;
  logic [LBUF_ADDR-1:0] rptr;
  logic [LBUF_ADDR-1:0] waddr_q;
  logic                 wen_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 run;
  logic                 prod;
  logic                 cons;
  logic                 row_end;
  logic [NW-1:0]        n_cfg;

  assign n_cfg = NW'(bus.cfg_acc_num) * NW'(bus.cfg_row_num);

  assign run     = state == RUN;
  assign cons    = run && valid != '0 && !bus.mac_stall;
  // A full ring may still issue when the same cycle frees a slot.
  assign prod    = run && issued < total && (occ < FULL || cons);
  assign row_end = idx == acc - CDATA_BIT'(1);

  assign bus.cmem_raddr = base + GBUS_ADDR'(issued);
  assign bus.cmem_ren   = prod;
  assign bus.lbuf_wen   = wen_q;
  assign bus.lbuf_waddr = waddr_q;
  assign bus.lbuf_raddr = rptr;
  assign bus.lbuf_ren   = cons;
  assign bus.abuf_ren   = cons;
  assign bus.abuf_raddr = LBUF_ADDR'(idx);
  assign bus.acc_last   = cons && row_end;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      base     <= '0;
      acc      <= '0;
      idx      <= '0;
      total    <= '0;
      issued   <= '0;
      consumed <= '0;
      occ      <= '0;
      valid    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wen_q <= prod;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            base     <= bus.cfg_base_addr;
            acc      <= bus.cfg_acc_num;
            total    <= n_cfg;
            idx      <= '0;
            issued   <= '0;
            consumed <= '0;
            occ      <= '0;
            valid    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            busy_q   <= 1'b1;
            if (n_cfg == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (prod) begin
            waddr_q <= wptr;
            wptr    <= wptr + LBUF_ADDR'(1);
            issued  <= issued + NW'(1);
          end
          unique case ({prod, cons})
            2'b10:   occ <= occ + (LBUF_ADDR+1)'(1);
            2'b01:   occ <= occ - (LBUF_ADDR+1)'(1);
            default: occ <= occ;
          endcase
          unique case ({wen_q, cons})
            2'b10:   valid <= valid + (LBUF_ADDR+1)'(1);
            2'b01:   valid <= valid - (LBUF_ADDR+1)'(1);
            default: valid <= valid;
          endcase
          if (cons) begin
            rptr     <= rptr + LBUF_ADDR'(1);
            consumed <= consumed + NW'(1);
            idx      <= row_end ? '0 : idx + CDATA_BIT'(1);
            if (consumed == total - NW'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mac_ctrl.sv
// Bench for core_mac_ctrl: job table, corner sequences and random
// jobs, each cycle compared against a word-count reference model.
module tb_core_mac_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_mac_ctrl_if bus ();

  core_mac_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] base;
    int          acc;
    int          rows;
    int          exp_reads;
    int          exp_lasts;
    int          exp_done;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(
    input logic busy, input logic done, input logic cren,
    input logic [11:0] caddr, input logic wen,
    input logic [3:0] waddr, input logic lren,
    input logic aren, input logic [3:0] raddr,
    input logic [3:0] araddr, input logic last);
    pack = {busy, done, cren, cren ? caddr : 12'h0,
            wen, wen ? waddr : 4'h0, lren, aren,
            lren ? raddr : 4'h0, aren ? araddr : 4'h0,
            last, 1'b0};
  endfunction

  // Model: word k is fetched from base+k, lands in slot k%16 one
  // cycle later, is readable the cycle after that, and is consumed
  // in order with in-row index k%acc. At most 16 words in flight.
  task automatic run_job(
    input string nm, input logic [11:0] base,
    input int acc, input int rows,
    input int st0, input int stlen, input bit rnd_stall,
    input int abort_c, input int rebusy_c,
    output int reads, output int lasts, output int done_c);
    int n, issued, consumed, written, pidx, fin, limit;
    bit pend, stall, run, aborted, ended;
    logic e_cren, e_wen, e_ren, e_done, e_busy, e_last;
    logic [11:0] e_addr;
    logic [31:0] ev, av;
    n = acc * rows;
    issued = 0; consumed = 0; written = 0;
    pidx = 0; pend = 0; ended = 0;
    fin = (n == 0) ? 1 : -1;
    reads = 0; lasts = 0; done_c = -1;
    limit = 4 * n + stlen + 200;
    for (int c = 0; c <= limit; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.start = 1'b1;
        bus.cfg_base_addr = base;
        bus.cfg_acc_num = 8'(acc);
        bus.cfg_row_num = 8'(rows);
      end else if (c == rebusy_c) begin
        bus.start = 1'b1;
        bus.cfg_base_addr = base ^ 12'h0F0;
        bus.cfg_acc_num = 8'd3;
        bus.cfg_row_num = 8'd2;
      end else begin
        bus.start = 1'b0;
        bus.cfg_base_addr = 12'($urandom);
        bus.cfg_acc_num = 8'($urandom);
        bus.cfg_row_num = 8'($urandom);
      end
      stall = rnd_stall ? ($urandom_range(0, 3) == 0)
                        : (c >= st0 && c < st0 + stlen);
      bus.mac_stall = stall;
      rst = (c == abort_c) ? 1'b0 : 1'b1;
      #1;
      aborted = abort_c >= 0 && c > abort_c;
      run = !aborted && n != 0 && c >= 1 &&
            (fin < 0 || c < fin);
      e_ren  = run && written > consumed && !stall;
      e_cren = run && issued < n &&
               (issued - consumed < 16 || e_ren);
      e_addr = base + 12'(issued);
      e_wen  = !aborted && pend;
      e_last = e_ren && (consumed % acc == acc - 1);
      e_done = !aborted && c == fin;
      e_busy = run || e_done;
      ev = pack(e_busy, e_done, e_cren, e_addr, e_wen,
                4'(pidx % 16), e_ren, e_ren,
                4'(consumed % 16),
                e_ren ? 4'(consumed % acc) : 4'h0, e_last);
      av = pack(bus.busy, bus.done, bus.cmem_ren,
                bus.cmem_raddr, bus.lbuf_wen, bus.lbuf_waddr,
                bus.lbuf_ren, bus.abuf_ren, bus.lbuf_raddr,
                bus.abuf_raddr, bus.acc_last);
      chk($sformatf("%s_cyc%0d", nm, c), av, ev);
      if (bus.lbuf_ren) reads++;
      if (bus.lbuf_ren && bus.acc_last) lasts++;
      if (bus.done && done_c < 0) done_c = c;
      if (e_wen) written++;
      pend = e_cren;
      pidx = issued;
      if (e_cren) issued++;
      if (e_ren) begin
        consumed++;
        if (consumed == n) fin = c + 1;
      end
      if (aborted || (fin >= 0 && c == fin + 1)) begin
        ended = 1;
        break;
      end
    end
    if (!ended) begin
      errors++;
      $display("FAIL %s_timeout actual=running required=idle",
               nm);
    end
    bus.start = 1'b0;
    bus.mac_stall = 1'b0;
    rst = 1'b1;
  endtask

  int r, l, d;

  initial begin
    tbl[0] = '{12'h100,  4, 1,  4, 1,  7};
    tbl[1] = '{12'hFF8, 16, 3, 48, 3, 51};
    tbl[2] = '{12'h000,  4, 0,  0, 0,  1};
    tbl[3] = '{12'h010,  0, 5,  0, 0,  1};
    tbl[4] = '{12'h7A0,  1, 7,  7, 7, 10};

    bus.start = 1'b0;
    bus.cfg_base_addr = '0;
    bus.cfg_acc_num = '0;
    bus.cfg_row_num = '0;
    bus.mac_stall = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        pack(bus.busy, bus.done, bus.cmem_ren, bus.cmem_raddr,
             bus.lbuf_wen, bus.lbuf_waddr, bus.lbuf_ren,
             bus.abuf_ren, bus.lbuf_raddr, bus.abuf_raddr,
             bus.acc_last),
        32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_job($sformatf("tbl%0d", i), tbl[i].base, tbl[i].acc,
              tbl[i].rows, -1, 0, 1'b0, -1, -1, r, l, d);
      chk($sformatf("tbl%0d_reads", i), r, tbl[i].exp_reads);
      chk($sformatf("tbl%0d_lasts", i), l, tbl[i].exp_lasts);
      chk($sformatf("tbl%0d_done", i), d, tbl[i].exp_done);
    end

    run_job("bp", 12'h040, 8, 4, 2, 30, 1'b0, -1, -1, r, l, d);
    chk("bp_reads", r, 32);
    chk("bp_lasts", l, 4);
    chk("bp_done", d, 64);

    run_job("abort", 12'h100, 4, 1, -1, 0, 1'b0, 5, -1, r, l, d);
    chk("abort_no_done", d, -1);
    run_job("after", 12'h100, 4, 1, -1, 0, 1'b0, -1, -1, r, l, d);
    chk("after_reads", r, 4);
    chk("after_done", d, 7);

    run_job("rebusy", 12'h100, 4, 1, -1, 0, 1'b0, -1, 3, r, l, d);
    chk("rebusy_reads", r, 4);
    chk("rebusy_done", d, 7);

    for (int j = 0; j < 6; j++) begin
      int ra, rr;
      ra = $urandom_range(1, 16);
      rr = $urandom_range(0, 6);
      run_job($sformatf("rnd%0d", j), 12'($urandom), ra, rr,
              -1, 0, 1'b1, -1, -1, r, l, d);
      chk($sformatf("rnd%0d_reads", j), r, ra * rr);
      chk($sformatf("rnd%0d_lasts", j), l, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
